// File: rtl/lap_stop_watch.sv
// lap_stop_watch
//   Run-time stopwatch (minutes / seconds / milliseconds) with a clock
//   prescaler that derives the millisecond tick from clk, a programmable
//   minute wrap point and a small lap FIFO that snapshots the running time.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, overrides every input
//   enable     in   run; counters advance on millisecond ticks while high
//   zero       in   clear time, prescaler, lap FIFO and lap_ovf (only while enable=0)
//   lap_req    in   push the current time into the lap FIFO
//   lap_rd     in   pop the lap FIFO head (ignored when empty)
//   min/sec/msec              out  live time
//   lap_min/lap_sec/lap_msec  out  FIFO head (0 when empty)
//   lap_valid  out  FIFO non-empty
//   lap_count  out  entries held, 0..LAP_DEPTH
//   lap_full   out  lap_count == LAP_DEPTH
//   lap_ovf    out  sticky: a lap_req was dropped because the FIFO was full
module lap_stop_watch #(
  parameter int TICKS_PER_MS = 1,
  parameter int MIN_LIMIT    = 63,
  parameter int LAP_DEPTH    = 4,
  parameter int LAP_AW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              zero,
  input  logic              lap_req,
  input  logic              lap_rd,
  output logic [6:0]        min,
  output logic [6:0]        sec,
  output logic [9:0]        msec,
  output logic [6:0]        lap_min,
  output logic [6:0]        lap_sec,
  output logic [9:0]        lap_msec,
  output logic              lap_valid,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              lap_ovf
);

  localparam int             PW       = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [6:0]     MIN_LAST = 7'(MIN_LIMIT);
  localparam logic [LAP_AW:0] DEPTH_C = (LAP_AW + 1)'(LAP_DEPTH);

  // time counters and prescaler
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    min_q, min_d;
  logic [6:0]    sec_q, sec_d;
  logic [9:0]    msec_q, msec_d;

  // lap FIFO: entries packed as {min, sec, msec}
  logic [23:0]       mem_q [LAP_DEPTH];
  logic [23:0]       mem_d [LAP_DEPTH];
  logic [LAP_AW-1:0] wr_q, wr_d;
  logic [LAP_AW-1:0] rd_q, rd_d;
  logic [LAP_AW:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [23:0]       head_q, head_d;
  logic              valid_q, valid_d;
  logic              full_q, full_d;

  logic clr_s;
  logic tick_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign clr_s  = zero & ~enable;
  assign tick_s = enable & (pre_q == PRE_LAST);

  // Next-state for prescaler and the cascaded min/sec/msec counters
  always_comb begin
    pre_d  = pre_q;
    min_d  = min_q;
    sec_d  = sec_q;
    msec_d = msec_q;
    if (clr_s) begin
      pre_d  = '0;
      min_d  = 7'd0;
      sec_d  = 7'd0;
      msec_d = 10'd0;
    end else if (tick_s) begin
      pre_d = '0;
      if (msec_q == 10'd999) begin
        msec_d = 10'd0;
        if (sec_q == 7'd59) begin
          sec_d = 7'd0;
          min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
        end else begin
          sec_d = sec_q + 7'd1;
        end
      end else begin
        msec_d = msec_q + 10'd1;
      end
    end else if (enable) begin
      pre_d = pre_q + PW'(1);
    end else begin
      pre_d = pre_q;  // paused: resume mid-period
    end
  end

  // A full FIFO still accepts a push when the same cycle pops the head.
  assign pop_s  = lap_rd & (cnt_q != '0);
  assign push_s = lap_req & ((cnt_q != DEPTH_C) | pop_s);
  assign drop_s = lap_req & ~push_s;

  // Next-state for the lap FIFO plus the registered head/flag outputs
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_s) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wr_q] = {min_q, sec_q, msec_q};
        wr_d        = wr_q + LAP_AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + LAP_AW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + (LAP_AW + 1)'(1);
        2'b01:   cnt_d = cnt_q - (LAP_AW + 1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
    // Head is taken from the post-update FIFO so it appears one cycle after a push.
    head_d  = (cnt_d == '0) ? 24'd0 : mem_d[rd_d];
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == DEPTH_C);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      min_q   <= 7'd0;
      sec_q   <= 7'd0;
      msec_q  <= 10'd0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        mem_q[i] <= 24'd0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      head_q  <= 24'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      msec_q  <= msec_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      head_q  <= head_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  assign min       = min_q;
  assign sec       = sec_q;
  assign msec      = msec_q;
  assign lap_min   = head_q[23:17];
  assign lap_sec   = head_q[16:10];
  assign lap_msec  = head_q[9:0];
  assign lap_valid = valid_q;
  assign lap_count = cnt_q;
  assign lap_full  = full_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_lap_stop_watch.sv
// Directed bench for lap_stop_watch. Instance a: TICKS_PER_MS=2, MIN_LIMIT=63,
// LAP_DEPTH=4. Instance b shares all inputs: TICKS_PER_MS=1, MIN_LIMIT=0, so a
// full minute wrap fits in a short run.
module tb_lap_stop_watch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, zero, lap_req, lap_rd;

  logic [6:0] a_min, a_sec, a_lap_min, a_lap_sec;
  logic [9:0] a_msec, a_lap_msec;
  logic       a_lap_valid, a_lap_full, a_lap_ovf;
  logic [2:0] a_lap_count;

  logic [6:0] b_min, b_sec, b_lap_min, b_lap_sec;
  logic [9:0] b_msec, b_lap_msec;
  logic       b_lap_valid, b_lap_full, b_lap_ovf;
  logic [2:0] b_lap_count;

  lap_stop_watch #(.TICKS_PER_MS(2), .MIN_LIMIT(63), .LAP_DEPTH(4), .LAP_AW(2)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .zero(zero), .lap_req(lap_req), .lap_rd(lap_rd),
    .min(a_min), .sec(a_sec), .msec(a_msec),
    .lap_min(a_lap_min), .lap_sec(a_lap_sec), .lap_msec(a_lap_msec),
    .lap_valid(a_lap_valid), .lap_count(a_lap_count), .lap_full(a_lap_full), .lap_ovf(a_lap_ovf)
  );

  lap_stop_watch #(.TICKS_PER_MS(1), .MIN_LIMIT(0), .LAP_DEPTH(4), .LAP_AW(2)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .zero(zero), .lap_req(lap_req), .lap_rd(lap_rd),
    .min(b_min), .sec(b_sec), .msec(b_msec),
    .lap_min(b_lap_min), .lap_sec(b_lap_sec), .lap_msec(b_lap_msec),
    .lap_valid(b_lap_valid), .lap_count(b_lap_count), .lap_full(b_lap_full), .lap_ovf(b_lap_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Single comparison point for every check in this bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges; outputs are stable 1 time unit after each edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Directed stimulus sequence
  initial begin
    rst = 1'b1; enable = 1'b0; zero = 1'b0; lap_req = 1'b0; lap_rd = 1'b0;
    cyc(1);
    chk("rst_min", a_min, 0);
    chk("rst_sec", a_sec, 0);
    chk("rst_msec", a_msec, 0);
    chk("rst_valid", a_lap_valid, 0);
    chk("rst_count", a_lap_count, 0);
    chk("rst_full", a_lap_full, 0);
    chk("rst_ovf", a_lap_ovf, 0);

    // 2000 enabled cycles: a sees 1000 ticks, b sees 2000
    rst = 1'b0; enable = 1'b1;
    cyc(2000);
    chk("run_a_msec", a_msec, 0);
    chk("run_a_sec", a_sec, 1);
    chk("run_a_min", a_min, 0);
    chk("run_b_sec", b_sec, 2);
    enable = 1'b0;
    cyc(10);
    chk("pause_msec", a_msec, 0);
    chk("pause_sec", a_sec, 1);

    zero = 1'b1;
    cyc(1);
    zero = 1'b0;
    chk("zero_sec", a_sec, 0);

    // five laps at 0.010 .. 0.050 into a depth-4 FIFO
    for (int k = 1; k <= 5; k++) begin
      enable = 1'b1;
      cyc(20);
      enable = 1'b0; lap_req = 1'b1;
      cyc(1);
      lap_req = 1'b0;
      if (k == 1) begin
        chk("lap1_valid", a_lap_valid, 1);
        chk("lap1_msec", a_lap_msec, 10);
      end
    end
    chk("fill_msec", a_msec, 50);
    chk("fill_count", a_lap_count, 4);
    chk("fill_full", a_lap_full, 1);
    chk("fill_ovf", a_lap_ovf, 1);
    chk("fill_head", a_lap_msec, 10);
    for (int k = 0; k < 4; k++) begin
      chk("pop_head", a_lap_msec, 10 * (k + 1));
      chk("pop_count", a_lap_count, 4 - k);
      lap_rd = 1'b1;
      cyc(1);
      lap_rd = 1'b0;
    end
    chk("empty_valid", a_lap_valid, 0);
    chk("empty_head", a_lap_msec, 0);
    chk("empty_ovf_sticky", a_lap_ovf, 1);
    lap_rd = 1'b1;
    cyc(1);
    lap_rd = 1'b0;
    chk("empty_rd_count", a_lap_count, 0);

    // zero ignored while running, honoured while paused (and beats lap_req)
    enable = 1'b1; zero = 1'b1;
    cyc(20);
    chk("zero_run_msec", a_msec, 60);
    enable = 1'b0; lap_req = 1'b1;
    cyc(1);
    zero = 1'b0; lap_req = 1'b0;
    chk("zero_msec", a_msec, 0);
    chk("zero_count", a_lap_count, 0);
    chk("zero_valid", a_lap_valid, 0);
    chk("zero_ovf", a_lap_ovf, 0);

    // full FIFO: simultaneous push and pop keeps count, no overflow
    for (int k = 1; k <= 4; k++) begin
      enable = 1'b1;
      cyc(20);
      enable = 1'b0; lap_req = 1'b1;
      cyc(1);
      lap_req = 1'b0;
    end
    enable = 1'b1;
    cyc(40);
    enable = 1'b0;
    chk("rw_pre_full", a_lap_full, 1);
    lap_req = 1'b1; lap_rd = 1'b1;
    cyc(1);
    lap_req = 1'b0; lap_rd = 1'b0;
    chk("rw_count", a_lap_count, 4);
    chk("rw_ovf", a_lap_ovf, 0);
    chk("rw_full", a_lap_full, 1);
    chk("rw_head", a_lap_msec, 20);
    lap_rd = 1'b1;
    cyc(3);
    lap_rd = 1'b0;
    chk("rw_tail", a_lap_msec, 60);
    chk("rw_tail_count", a_lap_count, 1);

    // reset mid-run with two laps held
    lap_req = 1'b1;
    cyc(1);
    lap_req = 1'b0;
    chk("two_laps", a_lap_count, 2);
    enable = 1'b1;
    cyc(7);
    rst = 1'b1; lap_req = 1'b1;
    cyc(1);
    rst = 1'b0; lap_req = 1'b0;
    chk("rst2_msec", a_msec, 0);
    chk("rst2_count", a_lap_count, 0);
    chk("rst2_valid", a_lap_valid, 0);
    chk("rst2_head", a_lap_msec, 0);

    // minute wrap on b (MIN_LIMIT=0); a runs at half rate alongside
    cyc(59999);
    chk("pre_wrap_b_sec", b_sec, 59);
    chk("pre_wrap_b_msec", b_msec, 999);
    chk("pre_wrap_b_min", b_min, 0);
    chk("pre_wrap_a_sec", a_sec, 29);
    chk("pre_wrap_a_msec", a_msec, 999);
    cyc(1);
    chk("wrap_b_min", b_min, 0);
    chk("wrap_b_sec", b_sec, 0);
    chk("wrap_b_msec", b_msec, 0);
    chk("wrap_a_sec", a_sec, 30);
    chk("wrap_a_msec", a_msec, 0);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
